// File: rtl/ddr2_write_arbiter.sv
// Two-client DDR2 write arbiter: grants one client per burst (address + two data
// beats), alternating round-robin, and steers that client's writes onto af/wdf.
module ddr2_write_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         c0_af_wr_en,
    input  logic [30:0]  c0_af_addr_din,
    input  logic         c0_wdf_wr_en,
    input  logic [127:0] c0_wdf_din,
    input  logic [15:0]  c0_wdf_mask_din,
    input  logic         c1_af_wr_en,
    input  logic [30:0]  c1_af_addr_din,
    input  logic         c1_wdf_wr_en,
    input  logic [127:0] c1_wdf_din,
    input  logic [15:0]  c1_wdf_mask_din,
    output logic         c0_af_full,
    output logic         c0_wdf_full,
    output logic         c1_af_full,
    output logic         c1_wdf_full,
    input  logic         af_full,
    input  logic         wdf_full,
    output logic         af_wr_en,
    output logic [30:0]  af_addr_din,
    output logic         wdf_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din,
    output logic [1:0]   gnt
);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

    state_t state;
    logic   owner;
    logic   pri;

    logic         busy;
    logic         own_af;
    logic         own_wdf;
    logic [30:0]  own_addr;
    logic [127:0] own_din;
    logic [15:0]  own_mask;
    logic         next_owner;

    assign busy     = (state != IDLE);
    assign own_af   = owner ? c1_af_wr_en     : c0_af_wr_en;
    assign own_wdf  = owner ? c1_wdf_wr_en    : c0_wdf_wr_en;
    assign own_addr = owner ? c1_af_addr_din  : c0_af_addr_din;
    assign own_din  = owner ? c1_wdf_din      : c0_wdf_din;
    assign own_mask = owner ? c1_wdf_mask_din : c0_wdf_mask_din;

    // On a tie the priority client wins; otherwise whoever is requesting.
    assign next_owner = (c0_af_wr_en & c1_af_wr_en) ? pri : c1_af_wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            pri   <= 1'b0;
            gnt   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (c0_af_wr_en | c1_af_wr_en) begin
                        owner <= next_owner;
                        gnt   <= next_owner ? 2'b10 : 2'b01;
                        state <= BEAT1;
                    end
                end
                BEAT1: begin
                    if (own_wdf & own_af) begin
                        state <= BEAT2;
                    end else if (!own_wdf && !own_af) begin
                        // Request withdrawn before any beat: release without touching pri.
                        state <= IDLE;
                        gnt   <= 2'b00;
                    end
                end
                BEAT2: begin
                    if (own_wdf) begin
                        pri   <= ~owner;
                        state <= IDLE;
                        gnt   <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign af_wr_en     = (state == BEAT1) & own_af & own_wdf;
    assign wdf_wr_en    = busy & own_wdf;
    assign af_addr_din  = busy ? own_addr : 31'd0;
    assign wdf_din      = busy ? own_din  : 128'd0;
    assign wdf_mask_din = busy ? own_mask : 16'hFFFF;

    // Only the owner sees the real downstream fulls; everyone else is held off.
    assign c0_af_full  = ~(busy & ~owner) | af_full;
    assign c0_wdf_full = ~(busy & ~owner) | wdf_full;
    assign c1_af_full  = ~(busy &  owner) | af_full;
    assign c1_wdf_full = ~(busy &  owner) | wdf_full;

endmodule
